alu_mp_seq: RTL
===============

Name: alu_mp_seq

Overview:
Multi-precision micro-sequencer that drives the shared 8-bit ALU for one 16-bit operation over several ALU steps. Supported operations are 16-bit subtract and multi-bit 16-bit shifts, chained through the ALU carry/borrow bit. It sits between the control unit and the ALU input mux: while seq_busy is high, the top-level mux routes this block's alu_* outputs to the ALU. Result handshake is valid/ready.

Parameters:
AMT_W, 4, width of shift-amount field; amounts 0..2^AMT_W-1.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept; high only in IDLE
req_op  input  2  00 SUB16, 01 SHL16, 10 SHR16, 11 reserved
req_a  input  16  operand A {hi,lo}
req_b  input  16  operand B (SUB16 only)
req_amt  input  AMT_W  shift count (shifts only)
alu_cmd  output  3  to ALU
alu_inA  output  8  to ALU
alu_inB  output  8  to ALU
alu_sc_i  output  1  to ALU carry in
alu_typesel  output  3  to ALU shift/inc-dec select
alu_rslt  input  8  from ALU (combinational)
alu_sc_o  input  1  from ALU
seq_busy  output  1  sequencer owns ALU (any state but IDLE/RESP)
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts
rsp_res  output  16  result
rsp_carry  output  1  SUB16: borrow (A<B unsigned); shifts: last bit shifted out
rsp_zero  output  1  rsp_res == 0
rsp_err  output  1  reserved op

Behaviour:
- One clock (clk). reset_n is asynchronous and active-low. Reset forces IDLE and clears all registers. All rsp_* outputs, seq_busy and alu_* outputs read 0 during reset, except alu_cmd = 3'b111 (pass). Reset mid-operation discards the operation, with no response.
- States: IDLE, SUB_LO, SUB_HI, DEC_HI, SH_A, SH_B, RESP.
- Accept: req_valid && req_ready at a rising edge latches op, A, B and amt. Requests are ignored outside IDLE.
- Each non-IDLE/RESP state is one ALU step. The ALU is combinational; alu_rslt/alu_sc_o are captured at the end of the step.
- In IDLE/RESP, ALU outputs: alu_cmd=111, inA=inB=0, sc_i=0, typesel=000.
- SUB16, IDLE→SUB_LO:
  - SUB_LO: cmd=110, inA=a_lo, inB=b_lo, sc_i=0. Capture res_lo and borrow_lo=sc_o. →SUB_HI.
  - SUB_HI: cmd=110, inA=a_hi, inB=b_hi, sc_i=0. Capture res_hi and bh=sc_o. Next is DEC_HI if borrow_lo, else RESP with carry=bh.
  - DEC_HI: cmd=001, typesel=100, inA=res_hi. Capture res_hi=rslt. carry = bh | (res_hi_prev==8'h00). →RESP.
- SHL16: count=amt. If amt==0, IDLE→RESP directly with res=A, carry=0. Otherwise each bit takes two steps:
  - SH_A: cmd=001, typesel=010, inA=lo. Capture lo and c=sc_o.
  - SH_B: cmd=001, typesel=011, inA=hi, sc_i=c. Capture hi and carry=sc_o.
  - Decrement count. Return to SH_A if count≠0, else RESP.
- SHR16: same structure as SHL16, high byte first:
  - SH_A: typesel=000 on hi.
  - SH_B: typesel=001 on lo, sc_i=c.
  - carry = sc_o of SH_B.
- Reserved op 11: IDLE→RESP with res=A, carry=0, err=1.
- Latency: N ALU steps means rsp_valid is high N edges after the accept edge. N=0 means rsp_valid is high right after the accept edge.
  - SUB16: N=2, or 3 with borrow.
  - Shift: N=2·amt.
- RESP: rsp_* are stable while rsp_valid && !rsp_ready. Handshake at an edge → IDLE. req_ready rises the next cycle, so there is no same-cycle turnaround.
- rsp_zero and rsp_err are registered with the result. rsp_zero is evaluated on the final 16-bit result.
- Width rules: all ALU arithmetic is 8-bit modulo 256. Result is the concatenation {res_hi,res_lo}.

Decomposition:
- Package alu_mp_pkg holds:
  - ALU command constants: ALU_SHIFT=3'b001, ALU_SUB=3'b110, ALU_PASS=3'b111.
  - typeselect constants: SHR0=000, SHRC=001, SHL0=010, SHLC=011, DEC=100.
  - req_op enum.
  - state enum.
- Single module; no sub-module. The ALU remains a separate instance at top level.

Test Plan:
- SUB16 A=0x1234 B=0x0134 → res=0x1100, carry=0, zero=0, rsp_valid 2 edges after accept, DEC_HI never entered.
- SUB16 A=0x1200 B=0x0001 → res=0x11FF, carry=0, 3 steps with DEC_HI seen (alu_typesel=100). A=0x0000 B=0x0001 → res=0xFFFF, carry=1.
- SHL16 A=0x8001 amt=1 → 0x0002, carry=1. A=0x1234 amt=4 → 0x2340, carry=1, 8 steps. amt=0 → 0x1234, carry=0, immediate response.
- SHR16 A=0x0003 amt=2 → res=0x0000, carry=1, zero=1. Check sc_i chaining on each SH_B.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_* stable, req_ready=0, new req_valid ignored. Release → one handshake, then req_ready=1 the next cycle.
- Assert reset_n=0 during SUB_HI → immediate IDLE, rsp_valid=0, seq_busy=0, alu_cmd=111. After release, a new SUB16 completes correctly. Reserved op → err=1, res=A.

Source files
------------

// File: rtl/alu_mp_pkg.sv
// Shared constants and types for the multi-precision ALU micro-sequencer.
package alu_mp_pkg;

  // ALU command encodings
  localparam logic [2:0] ALU_SHIFT = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_PASS  = 3'b111;

  // ALU shift / inc-dec type selects
  localparam logic [2:0] SHR0 = 3'b000;
  localparam logic [2:0] SHRC = 3'b001;
  localparam logic [2:0] SHL0 = 3'b010;
  localparam logic [2:0] SHLC = 3'b011;
  localparam logic [2:0] DEC  = 3'b100;

  typedef enum logic [1:0] {
    OP_SUB16 = 2'b00,
    OP_SHL16 = 2'b01,
    OP_SHR16 = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SUB_LO = 3'd1,
    ST_SUB_HI = 3'd2,
    ST_DEC_HI = 3'd3,
    ST_SH_A   = 3'd4,
    ST_SH_B   = 3'd5,
    ST_RESP   = 3'd6
  } state_e;

endpackage

// File: rtl/alu_mp_seq.sv
// Micro-sequencer that runs one 16-bit subtract or shift as a series of
// 8-bit steps on the shared ALU, chaining through the ALU carry/borrow bit.
module alu_mp_seq
  import alu_mp_pkg::*;
#(
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [AMT_W-1:0] req_amt,
  output logic [2:0]       alu_cmd,
  output logic [7:0]       alu_inA,
  output logic [7:0]       alu_inB,
  output logic             alu_sc_i,
  output logic [2:0]       alu_typesel,
  input  logic [7:0]       alu_rslt,
  input  logic             alu_sc_o,
  output logic             seq_busy,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_res,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err
);

  state_e           state;
  state_e           state_nxt;
  op_e              op;
  logic [7:0]       a_hi, a_lo, b_hi, b_lo;
  logic [7:0]       res_hi, res_lo;
  logic [AMT_W-1:0] count;
  logic             borrow_lo;
  logic             bh;
  logic             c;
  logic             carry;
  logic             zero;
  logic             err;

  assign req_ready = (state == ST_IDLE);
  assign seq_busy  = (state != ST_IDLE) && (state != ST_RESP);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_res   = {res_hi, res_lo};
  assign rsp_carry = carry;
  assign rsp_zero  = zero;
  assign rsp_err   = err;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state selection: one ALU step per busy state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          case (op_e'(req_op))
            OP_SUB16: state_nxt = ST_SUB_LO;
            OP_SHL16,
            OP_SHR16: state_nxt = (req_amt == '0) ? ST_RESP : ST_SH_A;
            default:  state_nxt = ST_RESP;
          endcase
        end
      end
      ST_SUB_LO: state_nxt = ST_SUB_HI;
      ST_SUB_HI: state_nxt = borrow_lo ? ST_DEC_HI : ST_RESP;
      ST_DEC_HI: state_nxt = ST_RESP;
      ST_SH_A:   state_nxt = ST_SH_B;
      // count still holds the pre-decrement value here
      ST_SH_B:   state_nxt = (count == AMT_W'(1)) ? ST_RESP : ST_SH_A;
      ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // ALU operand/command drive for the current step; pass-through when idle
  always_comb begin
    alu_cmd     = ALU_PASS;
    alu_inA     = 8'h00;
    alu_inB     = 8'h00;
    alu_sc_i    = 1'b0;
    alu_typesel = SHR0;
    case (state)
      ST_SUB_LO: begin
        alu_cmd = ALU_SUB;
        alu_inA = a_lo;
        alu_inB = b_lo;
      end
      ST_SUB_HI: begin
        alu_cmd = ALU_SUB;
        alu_inA = a_hi;
        alu_inB = b_hi;
      end
      ST_DEC_HI: begin
        alu_cmd     = ALU_SHIFT;
        alu_typesel = DEC;
        alu_inA     = res_hi;
      end
      ST_SH_A: begin
        alu_cmd = ALU_SHIFT;
        if (op == OP_SHL16) begin
          alu_typesel = SHL0;
          alu_inA     = res_lo;
        end else begin
          alu_typesel = SHR0;
          alu_inA     = res_hi;
        end
      end
      ST_SH_B: begin
        alu_cmd  = ALU_SHIFT;
        alu_sc_i = c;
        if (op == OP_SHL16) begin
          alu_typesel = SHLC;
          alu_inA     = res_hi;
        end else begin
          alu_typesel = SHRC;
          alu_inA     = res_lo;
        end
      end
      default: ;
    endcase
  end

  // Operand latch and per-step capture of ALU result and flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op        <= OP_SUB16;
      a_hi      <= 8'h00;
      a_lo      <= 8'h00;
      b_hi      <= 8'h00;
      b_lo      <= 8'h00;
      res_hi    <= 8'h00;
      res_lo    <= 8'h00;
      count     <= '0;
      borrow_lo <= 1'b0;
      bh        <= 1'b0;
      c         <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op             <= op_e'(req_op);
            {a_hi, a_lo}   <= req_a;
            {b_hi, b_lo}   <= req_b;
            count          <= req_amt;
            // Shifts work in place on the result bytes; zero-step ops respond with A
            {res_hi, res_lo} <= req_a;
            carry          <= 1'b0;
            zero           <= (req_a == 16'h0000);
            err            <= (req_op == OP_RSVD);
          end
        end
        ST_SUB_LO: begin
          res_lo    <= alu_rslt;
          borrow_lo <= alu_sc_o;
        end
        ST_SUB_HI: begin
          res_hi <= alu_rslt;
          bh     <= alu_sc_o;
          carry  <= alu_sc_o;
          zero   <= ({alu_rslt, res_lo} == 16'h0000);
        end
        ST_DEC_HI: begin
          // Decrementing a zero high byte propagates the low borrow out
          res_hi <= alu_rslt;
          carry  <= bh | (res_hi == 8'h00);
          zero   <= ({alu_rslt, res_lo} == 16'h0000);
        end
        ST_SH_A: begin
          if (op == OP_SHL16) res_lo <= alu_rslt;
          else                res_hi <= alu_rslt;
          c <= alu_sc_o;
        end
        ST_SH_B: begin
          if (op == OP_SHL16) begin
            res_hi <= alu_rslt;
            zero   <= ({alu_rslt, res_lo} == 16'h0000);
          end else begin
            res_lo <= alu_rslt;
            zero   <= ({res_hi, alu_rslt} == 16'h0000);
          end
          carry <= alu_sc_o;
          count <= count - AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
